serial_word_loader: RTL and testbench

Serial-to-parallel front end that collects `WIDTH` serial bits, LSB first, and presents the completed word together with a one-cycle `load` pulse. It sits directly upstream of the enabled, resettable flip-flop register stage. `word` drives the register's D input and `load` drives its enable. The downstream register therefore captures exactly one new value per completed frame.

---
 rtl/serial_word_loader.sv | 129 ++++++++++++
 tb/tb_serial_word_loader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader.sv
// serial_word_loader: collects WIDTH serial bits (LSB first) into a shift
// register and presents each completed word on `word` with a one-cycle
// `load` pulse, so a downstream enabled register captures one value per frame.
// Optional even-parity checking is compiled in with SERIAL_WORD_LOADER_PARITY_EN;
// without it frames are exactly WIDTH bits and `perr` is tied low.
module serial_word_loader #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       abort,
  output logic [WIDTH-1:0]           word,
  output logic                       load,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic                       perr
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam logic [CW-1:0] ALL_BITS = CW'(WIDTH);
`endif

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic             load_nxt;
  logic             perr_nxt;

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  // Even parity: data bits XOR parity bit must be zero for a good frame.
  function automatic logic parity_bad(input logic [WIDTH-1:0] data,
                                      input logic             pbit);
    parity_bad = (^data) ^ pbit;
  endfunction
`endif

  // A frame is in flight whenever the FSM has left IDLE.
  assign busy = (state != IDLE);

  // State, counter, shift register and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      sr    <= '0;
      word  <= '0;
      load  <= 1'b0;
      perr  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      sr    <= sr_nxt;
      word  <= word_nxt;
      load  <= load_nxt;
      perr  <= perr_nxt;
    end
  end

  // Next-state logic: abort beats sin_valid; pulses default low every cycle.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sr_nxt    = sr;
    word_nxt  = word;
    load_nxt  = 1'b0;
    perr_nxt  = 1'b0;

    if (abort) begin
      // Partial frame dropped; sr is fully rewritten by the next frame.
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (sin_valid) begin
      case (state)
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        PAR: begin
          // The bit arriving here is the parity bit, not data.
          if (parity_bad(sr, sin)) begin
            perr_nxt = 1'b1;
          end else begin
            word_nxt = sr;
            load_nxt = 1'b1;
          end
          state_nxt = IDLE;
          count_nxt = '0;
        end
`endif
        default: begin
          // IDLE and SHIFT both accept a data bit into sr[count].
          for (int i = 0; i < WIDTH; i++) begin
            if (count == CW'(i)) sr_nxt[i] = sin;
          end
          if (count == LAST_BIT) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            state_nxt = PAR;
            count_nxt = ALL_BITS;
`else
            word_nxt  = sr_nxt;
            load_nxt  = 1'b1;
            state_nxt = IDLE;
            count_nxt = '0;
`endif
          end else begin
            state_nxt = SHIFT;
            count_nxt = count + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Table-driven bench for serial_word_loader (WIDTH=8). Each row holds the
// inputs for one clock edge and the outputs expected just after that edge.
// Expectations follow the parity build when SERIAL_WORD_LOADER_PARITY_EN is set.
module tb_serial_word_loader;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, sin, sin_valid, abort;
  logic [W-1:0]  word;
  logic          load, busy, perr;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  serial_word_loader #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .abort(abort), .word(word), .load(load), .busy(busy),
    .count(count), .perr(perr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r, v, s, a;
    logic [W-1:0] ew;
    logic         el, eb, ep;
    int           ec;
  } vec_t;

  vec_t tbl[$];

  task automatic push(input logic r, v, s, a, input logic [W-1:0] ew,
                      input logic el, eb, input int ec, input logic ep = 1'b0);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.a = a;
    t.ew = ew; t.el = el; t.eb = eb; t.ec = ec; t.ep = ep;
    tbl.push_back(t);
  endtask

  // One complete frame; with gaps, an idle cycle follows every non-final bit.
  task automatic push_frame(input logic [W-1:0] data, input logic [W-1:0] prev,
                            input bit gaps, input logic pbit);
    for (int i = 0; i < W; i++) begin
      bit last = !PAR_EN && (i == W-1);
      push(0, 1, data[i], 0, last ? data : prev, last, !last, last ? 0 : i+1);
      if (gaps && !last) push(0, 0, 1'b1, 0, prev, 0, 1, i+1);
    end
    if (PAR_EN) begin
      bit good = ((^data) ^ pbit) == 1'b0;
      push(0, 1, pbit, 0, good ? data : prev, good, 0, 0, !good);
    end
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int row);
    @(negedge clk);
    reset = t.r; sin_valid = t.v; sin = t.s; abort = t.a;
    @(posedge clk);
    #1;
    chk("word",  row, 32'(word),  32'(t.ew));
    chk("load",  row, 32'(load),  32'(t.el));
    chk("busy",  row, 32'(busy),  32'(t.eb));
    chk("count", row, 32'(count), 32'(t.ec));
    chk("perr",  row, 32'(perr),  32'(t.ep));
  endtask

  initial begin
    reset = 1'b1; sin = 1'b1; sin_valid = 1'b1; abort = 1'b0;

    // Reset held two edges with valid data present.
    push(1, 1, 1, 0, 8'h00, 0, 0, 0);
    push(1, 1, 1, 0, 8'h00, 0, 0, 0);
    // Single frame 0xA5, then an idle cycle.
    push_frame(8'hA5, 8'h00, 0, 1'b0);
    push(0, 0, 0, 0, 8'hA5, 0, 0, 0);
    // 0x3C with gaps, then 0xC3 starting the edge right after the load edge.
    push_frame(8'h3C, 8'hA5, 1, 1'b0);
    push_frame(8'hC3, 8'h3C, 0, 1'b0);
    // Five bits of 0xFF, abort together with valid, then 0x81.
    for (int i = 0; i < 5; i++) push(0, 1, 1, 0, 8'hC3, 0, 1, i+1);
    push(0, 1, 1, 1, 8'hC3, 0, 0, 0);
    push_frame(8'h81, 8'hC3, 0, 1'b0);
    // Reset after three bits, then 0x5A.
    for (int i = 0; i < 3; i++) push(0, 1, 1, 0, 8'h81, 0, 1, i+1);
    push(1, 1, 1, 0, 8'h00, 0, 0, 0);
    push_frame(8'h5A, 8'h00, 0, 1'b0);
    // Abort landing on the final bit of a frame: no pulse, word holds.
    for (int i = 0; i < W-1; i++) push(0, 1, 0, 0, 8'h5A, 0, 1, i+1);
    if (PAR_EN) push(0, 1, 0, 0, 8'h5A, 0, 1, W);
    push(0, 1, 1, 1, 8'h5A, 0, 0, 0);
    push(0, 0, 0, 0, 8'h5A, 0, 0, 0);
    // Parity frames: 0xA5 good, 0x01 with parity 0 is bad.
    if (PAR_EN) begin
      push_frame(8'hA5, 8'h5A, 0, 1'b0);
      push_frame(8'h01, 8'hA5, 0, 1'b0);
    end

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Hand sequence: final bit coincides with reset -> no load, word cleared.
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      reset = 1'b0; sin_valid = 1'b1; sin = 1'b1; abort = 1'b0;
      @(posedge clk);
    end
    if (PAR_EN) begin
      @(negedge clk);
      sin = 1'b0;
      reset = 1'b1;
    end else begin
      @(negedge clk);
      reset = 1'b1;
    end
    // In the non-parity build the W-th bit edge above already completed;
    // check it landed, then confirm the reset edge clears everything.
    #1;
    if (!PAR_EN) begin
      chk("seq_load_before_reset", 0, 32'(load), 32'd1);
      chk("seq_word_before_reset", 0, 32'(word), 32'hFF);
    end
    @(posedge clk);
    #1;
    chk("seq_reset_load", 0, 32'(load), 32'd0);
    chk("seq_reset_word", 0, 32'(word), 32'h00);
    chk("seq_reset_busy", 0, 32'(busy), 32'd0);

    // Hand sequence: a long idle stretch keeps word/count stable, no pulses.
    @(negedge clk);
    reset = 1'b0; sin_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sin = i[0];
      @(posedge clk);
      #1;
      chk("idle_load",  i, 32'(load),  32'd0);
      chk("idle_count", i, 32'(count), 32'd0);
      chk("idle_word",  i, 32'(word),  32'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
